// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver. It oversamples serialInput on clkEn ticks and hands each byte to a valid/ready consumer.
// Latency: 2 clk of synchronizer delay. dataValid/frameError/overrun register on the clk edge after the stop-bit sampling tick.
// Backpressure: a byte is held while dataValid && !dataReady. A good frame arriving into a full holding register is dropped and overrun pulses.
//
// Ports:
//   clk, rstN               clock, async active-low reset
//   clkEn                   oversample tick (OVERSAMPLE x baud, one clk wide)
//   serialInput             raw serial line, idle high
//   dataReady               consumer accepts outputData when high with dataValid
//   outputData, dataValid   received byte and its valid flag
//   busy                    frame in progress (FSM not idle)
//   frameError, overrun     one-cycle error pulses
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       clkEn,
    input  logic       serialInput,
    input  logic       dataReady,
    output logic [7:0] outputData,
    output logic       dataValid,
    output logic       busy,
    output logic       frameError,
    output logic       overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          fe_q, fe_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= serialInput;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = vld_q;
        fe_d    = 1'b0;
        ovr_d   = 1'b0;

        // The consumer handshake runs every clk, independent of clkEn.
        if (vld_q && dataReady) begin
            vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (clkEn && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (clkEn) begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            idx_d   = '0;
                        end else begin
                            // The line went high again at mid start bit, so this was a glitch.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (clkEn) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s;
                        if (idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (clkEn) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                            // The holding register is free if it is empty or is being consumed this cycle.
                            if (!vld_q || dataReady) begin
                                data_d = shift_q;
                                vld_d  = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Wait for the line to return high, so a held-low line cannot retrigger a start.
                if (rx_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign outputData = data_q;
    assign dataValid  = vld_q;
    assign busy       = busy_q;
    assign frameError = fe_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       clkEn = 1'b0;
    logic       serialInput = 1'b1;
    logic       dataReady = 1'b0;
    logic [7:0] outputData;
    logic       dataValid;
    logic       busy;
    logic       frameError;
    logic       overrun;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .clkEn      (clkEn),
        .serialInput(serialInput),
        .dataReady  (dataReady),
        .outputData (outputData),
        .dataValid  (dataValid),
        .busy       (busy),
        .frameError (frameError),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference model: a one-entry holding slot plus delivered-byte and error counters.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = 8'h00;
    int         exp_fe = 0;
    int         exp_ovr = 0;
    int         obs_fe = 0;
    int         obs_ovr = 0;
    int         busy_cycles = 0;

    // Oversample tick: one clk high out of every four.
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c = (c + 1) % 4;
            clkEn = (c == 0);
        end
    end

    // Output monitor, sampled on the falling edge while inputs are stable.
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prev_hold = 1'b0;
            end else begin
                if (dataValid && dataReady) got_q.push_back(outputData);
                if (frameError) obs_fe++;
                if (overrun) obs_ovr++;
                if (busy) busy_cycles++;
                if (prev_hold) chk("data_stable", 32'(outputData), 32'(prev_data));
                prev_hold = dataValid && !dataReady;
                prev_data = outputData;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        serialInput = v;
        wait_clk(BIT_CLK);
    endtask

    task automatic set_ready(input logic v);
        dataReady = v;
        if (v && pend_v) begin
            exp_q.push_back(pend_d);
            pend_v = 1'b0;
        end
    endtask

    task automatic drain();
        set_ready(1'b1);
        wait_clk(2);
        set_ready(1'b0);
    endtask

    // Start bit, 8 data bits LSB first, then the given stop-bit value. The model is updated after the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
        if (!stop_v) begin
            exp_fe++;
        end else if (dataReady) begin
            exp_q.push_back(b);
        end else if (!pend_v) begin
            pend_v = 1'b1;
            pend_d = b;
        end else begin
            exp_ovr++;
        end
    endtask

    task automatic checkpoint(input string tag);
        int n;
        serialInput = 1'b1;
        wait_clk(2 * BIT_CLK);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        chk({tag, "_frame_err"}, 32'(obs_fe), 32'(exp_fe));
        chk({tag, "_overrun"}, 32'(obs_ovr), 32'(exp_ovr));
        chk({tag, "_valid"}, 32'(dataValid), 32'(pend_v));
        if (pend_v) chk({tag, "_held"}, 32'(outputData), 32'(pend_d));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       good;

        rstN = 1'b0;
        wait_clk(5);
        chk("rst_data", 32'(outputData), 32'h00);
        chk("rst_valid", 32'(dataValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fe", 32'(frameError), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rstN = 1'b1;
        wait_clk(10);

        // Clean frame held until the consumer is ready.
        set_ready(1'b0);
        send_frame(8'hA5, 1'b1);
        wait_clk(100);
        chk("clean_valid", 32'(dataValid), 32'd1);
        chk("clean_data", 32'(outputData), 32'hA5);
        drain();
        chk("clean_valid_cleared", 32'(dataValid), 32'd0);
        checkpoint("clean");

        // Low glitch for 4 ticks.
        busy_cycles = 0;
        serialInput = 1'b0;
        wait_clk(16);
        serialInput = 1'b1;
        wait_clk(BIT_CLK);
        chk("false_busy_seen", 32'(busy_cycles > 0), 32'd1);
        chk("false_valid", 32'(dataValid), 32'd0);
        checkpoint("false_start");

        // Framing error followed by a good frame.
        send_frame(8'h3C, 1'b0);
        serialInput = 1'b0;
        wait_clk(32);
        chk("ferr_busy_break", 32'(busy), 32'd1);
        chk("ferr_valid", 32'(dataValid), 32'd0);
        chk("ferr_pulse", 32'(obs_fe), 32'(exp_fe));
        wait_clk(32);
        serialInput = 1'b1;
        wait_clk(16);
        chk("ferr_busy_release", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1);
        drain();
        checkpoint("frame_err");

        // Overrun: two frames with no consumer.
        set_ready(1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checkpoint("overrun");
        drain();
        checkpoint("overrun_drain");

        // Streaming with the consumer always ready.
        set_ready(1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        checkpoint("stream");
        set_ready(1'b0);

        // Reset during data bit 4 of 0xC3.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        serialInput = 1'b0;
        wait_clk(32);
        rstN = 1'b0;
        wait_clk(2);
        chk("midrst_data", 32'(outputData), 32'h00);
        chk("midrst_valid", 32'(dataValid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fe", 32'(frameError), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        pend_v = 1'b0;
        serialInput = 1'b1;
        wait_clk(4);
        rstN = 1'b1;
        wait_clk(BIT_CLK);
        chk("midrst_busy_after", 32'(busy), 32'd0);
        send_frame(8'h7E, 1'b1);
        drain();
        checkpoint("reset_mid");

        // Random frames, stop-bit errors, consumer modes and gaps.
        for (int k = 0; k < 24; k++) begin
            set_ready($urandom_range(0, 2) == 0);
            rb   = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(rb, good);
            if (!good) begin
                send_bit(1'b0);
                send_bit(1'b1);
            end
            if ($urandom_range(0, 3) == 0) drain();
            wait_clk($urandom_range(0, 40));
        end
        set_ready(1'b0);
        checkpoint("random");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART: the downstream partner of the transmitter. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, idle high) from the serial line. Bit timing comes from an oversampling tick, `clkEn`, running at OVERSAMPLE × baud. Each received byte is presented on a valid/ready handshake to the consuming logic, with framing and overrun errors flagged.

## Interface
- OVERSAMPLE, default 16: number of `clkEn` ticks per bit period; must be even and ≥ 4.
- clk  input  1  system clock; all logic on rising edge.
- rstN  input  1  asynchronous, active-low reset.
- clkEn  input  1  oversample tick, one `clk` cycle wide, OVERSAMPLE × baud.
- serialInput  input  1  asynchronous serial line, idle high.
- dataReady  input  1  consumer accepts `outputData` when high with `dataValid`.
- outputData  output  8  last received byte.
- dataValid  output  1  `outputData` holds an unconsumed byte.
- busy  output  1  high while a frame is being received (state ≠ IDLE).
- frameError  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  one-cycle pulse when a good frame completes while `dataValid` is still high.

## Operation
- `serialInput` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized bit `rxS`.
- Tick counter: width $clog2(OVERSAMPLE). It advances only on `clkEn` and is cleared on every state entry.
- Bit index: 3 bits.
- FSM states:
  - IDLE: on a `clkEn` tick with `rxS==0` → START, counter = 0.
  - START: on the tick where counter == OVERSAMPLE/2−1 (mid start bit), sample `rxS`.
    - If 0: → DATA, counter = 0, index = 0.
    - If 1 (glitch): → IDLE, no output activity.
  - DATA: on the tick where counter == OVERSAMPLE−1, shift `rxS` into shift register bit [index]; counter = 0.
    - If index == 7: → STOP; otherwise index + 1.
  - STOP: on the tick where counter == OVERSAMPLE−1, sample `rxS`.
    - If 1: commit the frame (below) → IDLE.
    - If 0: pulse `frameError`, discard the byte → BREAK.
  - BREAK: wait for `rxS==1` (on any `clk`) → IDLE. This prevents a held-low line from retriggering START.
- Commit:
  - If `dataValid`==0, or `dataReady`==1 in the same cycle: `outputData` ← shift register, `dataValid` ← 1.
  - Otherwise the new byte is dropped, `outputData` is unchanged, and `overrun` pulses.
- Handshake:
  - `dataValid` clears on any cycle with `dataValid && dataReady`, unless a commit loads a new byte in that same cycle; then it stays 1 with the new data.
  - `outputData` is stable while `dataValid` is high.
- `clkEn` low: the FSM and counter hold. The handshake still operates every `clk`.

## Timing
- Reset values: `outputData` = 0x00, `dataValid` = 0, `busy` = 0, `frameError` = 0, `overrun` = 0, FSM = IDLE, synchronizer = 1.
- Reset asserted mid-frame aborts immediately. No `dataValid` or error pulses are produced for the partial frame.
- Synchronizer latency: 2 `clk` from `serialInput` to `rxS`.
- Data bits are sampled at the bit centre: (1.5 + n) bit periods after the detected falling edge, ±1 tick of quantization.
- `dataValid` rises and `frameError`/`overrun` pulse on the `clk` edge after the stop-bit sampling tick. All three are registered.
- `busy` is registered from the state: high from the edge after start detection until the edge after return to IDLE. It stays high throughout BREAK.
- Back-to-back frames: a new start edge is accepted on the first `clkEn` tick after returning to IDLE. No extra idle time is required beyond the stop bit's second half.

## Test plan
- Clean frame: OVERSAMPLE=16, `clkEn` every 4 `clk`, send 0xA5 with `dataReady`=0 → `outputData`=0xA5, `dataValid` held high until `dataReady` pulses, then 0; `frameError`/`overrun` stay 0.
- False start: drive line low for 4 ticks, then high → FSM returns to IDLE, `busy` pulses then 0, `dataValid` stays 0.
- Framing error: send 0x3C with stop bit 0, hold low for 2 bit times → one `frameError` pulse, `dataValid` 0, `busy` high until line returns high; a following 0x5A frame is received correctly.
- Overrun: send 0x11 then 0x22 back-to-back with `dataReady`=0 → `outputData`=0x11, one `overrun` pulse at the end of the second frame.
- Streaming: send 0x00, 0xFF, 0x81 back-to-back with `dataReady`=1 → three `dataValid` pulses with those values in order, no errors.
- Reset mid-frame: assert `rstN`=0 during data bit 4 of 0xC3 → all outputs at reset values; a subsequent 0x7E frame is received correctly.
